bsg_credit_counter_down_up_drain: RTL and testbench

//   Sender-side credit tracker: the counterpart to the receiver-side clear/up counter.
//   - Receiver counts freed entries up and returns them as credits.
//   - This block spends credits on each accepted send and restores them on credit return.
//   - ready_o gates the sender's valid.
//   - A drain handshake lets the control plane wait until every credit is home.
//

---
 rtl/bsg_credit_pkg.sv | 18 +
 rtl/bsg_credit_counter_core.sv | 43 ++++
 rtl/bsg_credit_counter_down_up_drain.sv | 90 +++++++++
 tb/tb_bsg_credit_counter_down_up_drain.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/bsg_credit_pkg.sv
// Shared types and width helpers for the credit-tracking blocks.
package bsg_credit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int ptr_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

  function automatic int ret_w(input int ret_max);
    return $clog2(ret_max + 1);
  endfunction

endpackage

// File: rtl/bsg_credit_counter_core.sv
// Saturating up-by-n / down-by-1 credit counter with clear and sticky overflow.
module bsg_credit_counter_core
  import bsg_credit_pkg::*;
#(
  parameter int max_val_p  = 63,
  parameter int init_val_p = 63,
  parameter int ret_max_p  = 7,
  localparam int ptr_w_lp  = ptr_w(max_val_p),
  localparam int ret_w_lp  = ret_w(ret_max_p)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                clear_i,
  input  logic [ret_w_lp-1:0] inc_i,
  input  logic                dec_i,
  output logic [ptr_w_lp-1:0] count_o,
  output logic [ptr_w_lp-1:0] count_nxt_o,
  output logic                overflow_o
);

  localparam int sum_w_lp = ptr_w_lp + 1;
  localparam logic [ptr_w_lp-1:0] max_lp  = ptr_w_lp'(max_val_p);
  localparam logic [ptr_w_lp-1:0] init_lp = ptr_w_lp'(init_val_p);

  logic [sum_w_lp-1:0] sum;
  logic                over;

  // One extra bit holds count + a full return batch without wrapping.
  assign sum         = {1'b0, count_o} + sum_w_lp'(inc_i) - sum_w_lp'(dec_i);
  assign over        = sum > sum_w_lp'(max_val_p);
  assign count_nxt_o = over ? max_lp : sum[ptr_w_lp-1:0];

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      count_o    <= init_lp;
      overflow_o <= 1'b0;
    end else begin
      count_o <= count_nxt_o;
      if (over) overflow_o <= 1'b1;
    end
  end

endmodule

// File: rtl/bsg_credit_counter_down_up_drain.sv
// Sender-side credit tracker: spends a credit per accepted send, restores returned
// credits, and runs a drain handshake that waits until every credit is home.
module bsg_credit_counter_down_up_drain
  import bsg_credit_pkg::*;
#(
  parameter int max_val_p  = 63,
  parameter int init_val_p = 63,
  parameter int ret_max_p  = 7,
  localparam int ptr_w_lp  = ptr_w(max_val_p),
  localparam int ret_w_lp  = ret_w(ret_max_p)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                clear_i,
  input  logic                v_i,
  output logic                ready_o,
  input  logic                credit_v_i,
  input  logic [ret_w_lp-1:0] credit_cnt_i,
  input  logic                drain_req_i,
  output logic                drain_ack_o,
  output logic                credits_full_o,
  output logic                overflow_o,
  output logic [ptr_w_lp-1:0] count_o
);

  if (init_val_p > max_val_p) begin : g_bad_init
    $error("init_val_p must not exceed max_val_p");
  end
  if (ret_max_p > max_val_p) begin : g_bad_ret
    $error("ret_max_p must not exceed max_val_p");
  end

  localparam logic [ptr_w_lp-1:0] max_lp = ptr_w_lp'(max_val_p);

  state_e              state, state_n;
  logic                ack_n;
  logic                dec;
  logic [ret_w_lp-1:0] inc;
  logic [ptr_w_lp-1:0] count_nxt;

  assign ready_o        = (count_o != '0) && (state == IDLE);
  assign dec            = v_i & ready_o;
  assign inc            = credit_v_i ? credit_cnt_i : '0;
  assign credits_full_o = (count_o == max_lp);

  bsg_credit_counter_core #(
    .max_val_p (max_val_p),
    .init_val_p(init_val_p),
    .ret_max_p (ret_max_p)
  ) core (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .clear_i    (clear_i),
    .inc_i      (inc),
    .dec_i      (dec),
    .count_o    (count_o),
    .count_nxt_o(count_nxt),
    .overflow_o (overflow_o)
  );

  // A clear leaves the state alone; a full reload is seen as complete one cycle later.
  always_comb begin
    state_n = state;
    ack_n   = 1'b0;
    case (state)
      IDLE:  if (drain_req_i) state_n = DRAIN;
      DRAIN: begin
        if (!drain_req_i) begin
          state_n = IDLE;
        end else if (!clear_i && (count_nxt == max_lp)) begin
          state_n = DONE;
          ack_n   = 1'b1;
        end
      end
      DONE:    if (!drain_req_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= IDLE;
      drain_ack_o <= 1'b0;
    end else begin
      state       <= state_n;
      drain_ack_o <= ack_n;
    end
  end

endmodule

// File: tb/tb_bsg_credit_counter_down_up_drain.sv
// Self-checking bench: hand-written vector table plus a reference model feeding a scoreboard.
module tb_bsg_credit_counter_down_up_drain;

  logic       clk_i = 1'b0;
  logic       reset_i, clear_i, v_i, credit_v_i, drain_req_i;
  logic [2:0] credit_cnt_i;
  logic       ready_o, drain_ack_o, credits_full_o, overflow_o;
  logic [5:0] count_o;

  bsg_credit_counter_down_up_drain dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .clear_i       (clear_i),
    .v_i           (v_i),
    .ready_o       (ready_o),
    .credit_v_i    (credit_v_i),
    .credit_cnt_i  (credit_cnt_i),
    .drain_req_i   (drain_req_i),
    .drain_ack_o   (drain_ack_o),
    .credits_full_o(credits_full_o),
    .overflow_o    (overflow_o),
    .count_o       (count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int rst, clr, v, cv, cn, drn;
    int ec, er, eo, ea;
  } vec_t;

  typedef struct {
    int c, r, f, o, a;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state (0 idle, 1 draining, 2 done)
  int m_cnt = 63, m_ovf = 0, m_st = 0, m_ack = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int rst, input int clr, input int v, input int cv,
                     input int cn, input int drn);
    exp_t e;
    int   rdy, nxt, sat;
    reset_i      = (rst != 0);
    clear_i      = (clr != 0);
    v_i          = (v != 0);
    credit_v_i   = (cv != 0);
    credit_cnt_i = 3'(cn);
    drain_req_i  = (drn != 0);

    rdy = (m_cnt != 0 && m_st == 0) ? 1 : 0;
    if (rst != 0) begin
      m_cnt = 63; m_ovf = 0; m_st = 0; m_ack = 0;
    end else begin
      nxt   = m_cnt + ((cv != 0) ? cn : 0) - ((v != 0 && rdy != 0) ? 1 : 0);
      sat   = (nxt > 63) ? 63 : nxt;
      m_ack = 0;
      case (m_st)
        0: if (drn != 0) m_st = 1;
        1: begin
          if (drn == 0) m_st = 0;
          else if (clr == 0 && sat == 63) begin m_st = 2; m_ack = 1; end
        end
        default: if (drn == 0) m_st = 0;
      endcase
      if (clr != 0) begin
        m_cnt = 63; m_ovf = 0;
      end else begin
        m_cnt = sat;
        if (nxt > 63) m_ovf = 1;
      end
    end
    e.c = m_cnt;
    e.r = (m_cnt != 0 && m_st == 0) ? 1 : 0;
    e.f = (m_cnt == 63) ? 1 : 0;
    e.o = m_ovf;
    e.a = m_ack;
    sb.push_back(e);

    @(posedge clk_i);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("sb_count", int'(count_o), e.c);
      chk("sb_ready", int'(ready_o), e.r);
      chk("sb_full", int'(credits_full_o), e.f);
      chk("sb_ovf", int'(overflow_o), e.o);
      chk("sb_ack", int'(drain_ack_o), e.a);
    end
  endtask

  initial begin
    int drn;
    reset_i = 1'b1; clear_i = 1'b0; v_i = 1'b0; credit_v_i = 1'b0;
    credit_cnt_i = 3'd0; drain_req_i = 1'b0;

    // Reset state
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("reset_count", int'(count_o), 63);
    chk("reset_ready", int'(ready_o), 1);
    chk("reset_ovf", int'(overflow_o), 0);
    chk("reset_ack", int'(drain_ack_o), 0);

    // Continuous sends drain all credits, then stall at zero
    for (int k = 1; k <= 70; k++) begin
      cyc(0, 0, 1, 0, 0, 0);
      chk("burst_count", int'(count_o), (k <= 63) ? 63 - k : 0);
      chk("burst_ready", int'(ready_o), (k < 63) ? 1 : 0);
    end

    // rst clr v cv cn drn | count ready ovf ack
    tbl.push_back('{0, 0, 0, 1, 7, 0,   7, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 3, 0,  10, 1, 0, 0});
    tbl.push_back('{0, 0, 1, 1, 3, 0,  12, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 7, 0,  19, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 7, 0,  26, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 7, 0,  33, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 7, 0,  40, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 1,  40, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 1, 7, 1,  47, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 1, 7, 1,  54, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 1, 7, 1,  61, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 1, 2, 1,  63, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 1,  63, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 0, 0,  63, 1, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 0, 0,  62, 1, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 0, 0,  61, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 5, 0,  63, 1, 1, 0});
    tbl.push_back('{0, 1, 0, 0, 0, 0,  63, 1, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 0, 0,  62, 1, 0, 0});
    tbl.push_back('{0, 1, 1, 1, 7, 0,  63, 1, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 0, 0,  62, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 1,  62, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 1,  63, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0,  63, 1, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 0, 0,  62, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 1,  62, 0, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 0, 1,  63, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 1,  63, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 1,  63, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0,  63, 1, 0, 0});

    foreach (tbl[i]) begin
      cyc(tbl[i].rst, tbl[i].clr, tbl[i].v, tbl[i].cv, tbl[i].cn, tbl[i].drn);
      chk($sformatf("vec%0d_count", i), int'(count_o), tbl[i].ec);
      chk($sformatf("vec%0d_ready", i), int'(ready_o), tbl[i].er);
      chk($sformatf("vec%0d_ovf", i), int'(overflow_o), tbl[i].eo);
      chk($sformatf("vec%0d_ack", i), int'(drain_ack_o), tbl[i].ea);
    end

    // Randomized traffic against the model
    drn = 0;
    for (int k = 0; k < 600; k++) begin
      chk("ready_at_zero", int'(ready_o && (count_o == 6'd0)), 0);
      if ($urandom_range(0, 14) == 0) drn = 1 - drn;
      cyc(($urandom_range(0, 149) == 0) ? 1 : 0,
          ($urandom_range(0, 59) == 0) ? 1 : 0,
          int'($urandom_range(0, 1)),
          ($urandom_range(0, 2) == 0) ? 1 : 0,
          int'($urandom_range(0, 7)),
          drn);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
